// File: rtl/route_pkg.sv
// route_pkg: port encoding and route-decision helper shared by the tree router blocks.
package route_pkg;

    typedef enum logic [1:0] {
        PORT_DN0 = 2'd0,
        PORT_DN1 = 2'd1,
        PORT_UP  = 2'd2
    } port_e;

    localparam int NUM_PORTS = 3;
    localparam int CNT_W     = 16;

    // The address is passed zero-extended to 32 bits so one helper serves any ADDR_W.
    // The top LEVEL address bits must match the node prefix, otherwise the packet goes up.
    // The bit just below the prefix then picks the child.
    function automatic port_e route_decide(
        input logic [31:0] addr,
        input int          addr_w,
        input int          level,
        input logic [31:0] prefix
    );
        logic [31:0] prefix_mask;
        logic [31:0] addr_hi;
        logic [31:0] dir_vec;
        logic        in_prefix;
        port_e       result;
        prefix_mask = (32'd1 << level) - 32'd1;
        addr_hi     = addr >> (addr_w - level);
        dir_vec     = addr >> (addr_w - 1 - level);
        in_prefix   = (level == 0) || ((addr_hi & prefix_mask) == (prefix & prefix_mask));
        if (!in_prefix) begin
            result = PORT_UP;
        end else if (dir_vec[0]) begin
            result = PORT_DN1;
        end else begin
            result = PORT_DN0;
        end
        return result;
    endfunction

endpackage

// File: rtl/route_fifo.sv
// route_fifo: small valid/ready FIFO for one router output.
// The head entry is visible combinationally, so a push into an empty FIFO
// appears on rd_valid/rd_data the cycle after the write edge.
module route_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              wr_fire;
    logic              rd_fire;

    // Ready comes from registered occupancy only: a pop this cycle frees space next cycle.
    assign wr_ready = (count_q != FULL_CNT);
    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready;

    // Next-state pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/tree_route_node.sv
// tree_route_node: one node of an address-routed tree. Each ingress packet is
// steered to child 0, child 1 or the parent, each through its own FIFO.
// Optional per-route packet counters are built when TREE_ROUTE_STATS_EN is defined.
module tree_route_node
    import route_pkg::*;
#(
    parameter int DATA_W      = 9,
    parameter int ADDR_W      = 4,
    parameter int LEVEL       = 0,
    parameter int NODE_PREFIX = 0,
    parameter int DEPTH       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              dn0_valid,
    input  logic              dn0_ready,
    output logic [DATA_W-1:0] dn0_data,
    output logic              dn1_valid,
    input  logic              dn1_ready,
    output logic [DATA_W-1:0] dn1_data,
    output logic              up_valid,
    input  logic              up_ready,
    output logic [DATA_W-1:0] up_data,
    output logic              sel_valid,
    output logic [1:0]        sel_port
`ifdef TREE_ROUTE_STATS_EN
    ,
    output logic [15:0]       cnt_dn0,
    output logic [15:0]       cnt_dn1,
    output logic [15:0]       cnt_up
`endif
);

    port_e                route_sel;
    logic                 accept;
    logic [NUM_PORTS-1:0] fifo_wr_valid;
    logic [NUM_PORTS-1:0] fifo_wr_ready;
    logic [NUM_PORTS-1:0] fifo_rd_valid;
    logic [NUM_PORTS-1:0] fifo_rd_ready;
    logic [DATA_W-1:0]    fifo_rd_data [NUM_PORTS];
    logic                 sel_valid_q, sel_valid_d;
    logic [1:0]           sel_port_q, sel_port_d;

    assign route_sel = route_decide(32'(in_data[DATA_W-1 -: ADDR_W]), ADDR_W, LEVEL,
                                    32'(NODE_PREFIX));

    // Steer the packet to its FIFO; ready reflects only the FIFO this packet targets.
    always_comb begin
        fifo_wr_valid = '0;
        in_ready      = 1'b0;
        case (route_sel)
            PORT_DN0: begin
                fifo_wr_valid[0] = in_valid;
                in_ready         = fifo_wr_ready[0];
            end
            PORT_DN1: begin
                fifo_wr_valid[1] = in_valid;
                in_ready         = fifo_wr_ready[1];
            end
            PORT_UP: begin
                fifo_wr_valid[2] = in_valid;
                in_ready         = fifo_wr_ready[2];
            end
            default: begin
                fifo_wr_valid = '0;
                in_ready      = 1'b0;
            end
        endcase
    end

    assign accept = in_valid & in_ready;

    assign fifo_rd_ready = {up_ready, dn1_ready, dn0_ready};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            route_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .wr_valid (fifo_wr_valid[gi]),
                .wr_ready (fifo_wr_ready[gi]),
                .wr_data  (in_data),
                .rd_valid (fifo_rd_valid[gi]),
                .rd_ready (fifo_rd_ready[gi]),
                .rd_data  (fifo_rd_data[gi])
            );
        end
    endgenerate

    assign dn0_valid = fifo_rd_valid[0];
    assign dn0_data  = fifo_rd_data[0];
    assign dn1_valid = fifo_rd_valid[1];
    assign dn1_data  = fifo_rd_data[1];
    assign up_valid  = fifo_rd_valid[2];
    assign up_data   = fifo_rd_data[2];

    // Decision trace: pulse for one cycle per acceptance, port held otherwise.
    always_comb begin
        sel_valid_d = accept;
        sel_port_d  = sel_port_q;
        if (accept) begin
            sel_port_d = route_sel;
        end
    end

    // Decision trace registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_valid_q <= 1'b0;
            sel_port_q  <= 2'd0;
        end else begin
            sel_valid_q <= sel_valid_d;
            sel_port_q  <= sel_port_d;
        end
    end

    assign sel_valid = sel_valid_q;
    assign sel_port  = sel_port_q;

`ifdef TREE_ROUTE_STATS_EN
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stat
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Saturating count of packets accepted on this route.
            always_comb begin
                cnt_d = cnt_q;
                if (fifo_wr_valid[gi] && fifo_wr_ready[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign cnt_dn0 = g_stat[0].cnt_q;
    assign cnt_dn1 = g_stat[1].cnt_q;
    assign cnt_up  = g_stat[2].cnt_q;
`endif

endmodule

// File: tb/tb_tree_route_node.sv
// tb_tree_route_node: directed checks of a root node (LEVEL=0) and an inner
// node (LEVEL=2, prefix 2'b10). Counter checks run when TREE_ROUTE_STATS_EN is defined.
module tb_tree_route_node;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Root node signals
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [8:0] a_in_data = '0;
    logic       a_dn0_valid, a_dn1_valid, a_up_valid;
    logic       a_dn0_ready = 1'b1, a_dn1_ready = 1'b1, a_up_ready = 1'b1;
    logic [8:0] a_dn0_data, a_dn1_data, a_up_data;
    logic       a_sel_valid;
    logic [1:0] a_sel_port;

    // Level-2 node signals
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [8:0] b_in_data = '0;
    logic       b_dn0_valid, b_dn1_valid, b_up_valid;
    logic       b_dn0_ready = 1'b1, b_dn1_ready = 1'b1, b_up_ready = 1'b1;
    logic [8:0] b_dn0_data, b_dn1_data, b_up_data;
    logic       b_sel_valid;
    logic [1:0] b_sel_port;

`ifdef TREE_ROUTE_STATS_EN
    logic [15:0] a_cnt_dn0, a_cnt_dn1, a_cnt_up;
    logic [15:0] b_cnt_dn0, b_cnt_dn1, b_cnt_up;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tree_route_node #(.DATA_W(9), .ADDR_W(4), .LEVEL(0), .NODE_PREFIX(0), .DEPTH(2)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .dn0_valid (a_dn0_valid),
        .dn0_ready (a_dn0_ready),
        .dn0_data  (a_dn0_data),
        .dn1_valid (a_dn1_valid),
        .dn1_ready (a_dn1_ready),
        .dn1_data  (a_dn1_data),
        .up_valid  (a_up_valid),
        .up_ready  (a_up_ready),
        .up_data   (a_up_data),
        .sel_valid (a_sel_valid),
        .sel_port  (a_sel_port)
`ifdef TREE_ROUTE_STATS_EN
        ,
        .cnt_dn0   (a_cnt_dn0),
        .cnt_dn1   (a_cnt_dn1),
        .cnt_up    (a_cnt_up)
`endif
    );

    tree_route_node #(.DATA_W(9), .ADDR_W(4), .LEVEL(2), .NODE_PREFIX(2), .DEPTH(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .dn0_valid (b_dn0_valid),
        .dn0_ready (b_dn0_ready),
        .dn0_data  (b_dn0_data),
        .dn1_valid (b_dn1_valid),
        .dn1_ready (b_dn1_ready),
        .dn1_data  (b_dn1_data),
        .up_valid  (b_up_valid),
        .up_ready  (b_up_ready),
        .up_data   (b_up_data),
        .sel_valid (b_sel_valid),
        .sel_port  (b_sel_port)
`ifdef TREE_ROUTE_STATS_EN
        ,
        .cnt_dn0   (b_cnt_dn0),
        .cnt_dn1   (b_cnt_dn1),
        .cnt_up    (b_cnt_up)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
            $display("  ok   %-22s value=%0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("rst_a_dn0_valid", 32'(a_dn0_valid), 32'd0);
        check("rst_a_sel_valid", 32'(a_sel_valid), 32'd0);
        check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        check("rst_b_up_valid",  32'(b_up_valid),  32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // ---------------- root routing ----------------
        a_in_valid = 1'b1;
        a_in_data  = 9'b0_1010_1010;
        #1;
        check("a_dn0_in_ready", 32'(a_in_ready), 32'd1);
        step();
        a_in_valid = 1'b0;
        check("a_dn0_sel_valid", 32'(a_sel_valid), 32'd1);
        check("a_dn0_sel_port",  32'(a_sel_port),  32'd0);
        check("a_dn0_valid",     32'(a_dn0_valid), 32'd1);
        check("a_dn0_data",      32'(a_dn0_data),  32'h0AA);
        check("a_dn0_dn1_idle",  32'(a_dn1_valid), 32'd0);
        step();
        check("a_sel_pulse_end", 32'(a_sel_valid), 32'd0);
        check("a_dn0_drained",   32'(a_dn0_valid), 32'd0);

        a_in_valid = 1'b1;
        a_in_data  = 9'b1_0110_0110;
        step();
        a_in_valid = 1'b0;
        check("a_dn1_sel_port", 32'(a_sel_port),  32'd1);
        check("a_dn1_valid",    32'(a_dn1_valid), 32'd1);
        check("a_dn1_data",     32'(a_dn1_data),  32'h166);
        step();

        // ---------------- level-2 routing ----------------
        b_in_valid = 1'b1;
        b_in_data  = {4'b1011, 5'h0A};
        step();
        check("b_1011_sel_port", 32'(b_sel_port),  32'd1);
        check("b_1011_dn1_data", 32'(b_dn1_data),  32'h16A);
        check("b_1011_dn1_val",  32'(b_dn1_valid), 32'd1);
        b_in_data = {4'b0011, 5'h15};
        step();
        check("b_0011_sel_port", 32'(b_sel_port), 32'd2);
        check("b_0011_up_valid", 32'(b_up_valid), 32'd1);
        check("b_0011_up_data",  32'(b_up_data),  32'h075);
        b_in_data = {4'b1001, 5'h03};
        step();
        b_in_valid = 1'b0;
        check("b_1001_sel_port", 32'(b_sel_port),  32'd0);
        check("b_1001_dn0_data", 32'(b_dn0_data),  32'h123);
        step();

        // ---------------- blocked dn0, dn1 still flows ----------------
        a_dn0_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 9'h011;
        #1;
        check("blk_p1_ready", 32'(a_in_ready), 32'd1);
        step();
        a_in_data = 9'h022;
        #1;
        check("blk_p2_ready", 32'(a_in_ready), 32'd1);
        step();
        a_in_data = 9'h033;
        #1;
        check("blk_p3_ready", 32'(a_in_ready), 32'd0);
        step();
        check("blk_p3_no_sel",  32'(a_sel_valid), 32'd0);
        check("blk_head_held",  32'(a_dn0_data),  32'h011);
        a_in_data = 9'h1AB;
        #1;
        check("blk_dn1_ready", 32'(a_in_ready), 32'd1);
        step();
        check("blk_dn1_sel",   32'(a_sel_port),  32'd1);
        check("blk_dn1_data",  32'(a_dn1_data),  32'h1AB);
        check("blk_dn0_stable", 32'(a_dn0_data), 32'h011);

        // ---------------- full FIFO: pop and push offered together ----------------
        a_in_data   = 9'h033;
        a_dn0_ready = 1'b1;
        #1;
        check("full_pop_ready", 32'(a_in_ready), 32'd0);
        step();
        check("full_no_accept", 32'(a_sel_valid), 32'd0);
        check("full_head_p2",   32'(a_dn0_data),  32'h022);
        check("full_now_ready", 32'(a_in_ready),  32'd1);
        step();
        a_in_valid = 1'b0;
        check("full_accept_sel", 32'(a_sel_valid), 32'd1);
        check("full_head_p3",    32'(a_dn0_data),  32'h033);
        step();
        check("full_drained", 32'(a_dn0_valid), 32'd0);

        // ---------------- reset mid-operation ----------------
        b_up_ready = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = {4'b0011, 5'h15};
        step();
        b_in_data  = {4'b0111, 5'h01};
        step();
        b_in_valid = 1'b0;
        check("mid_up_valid", 32'(b_up_valid), 32'd1);
        check("mid_up_data",  32'(b_up_data),  32'h075);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_up_valid",  32'(b_up_valid),  32'd0);
        check("mid_rst_sel_valid", 32'(b_sel_valid), 32'd0);
        step();
        rst = 1'b0;
        b_up_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_up_idle", 32'(b_up_valid), 32'd0);
        end

`ifdef TREE_ROUTE_STATS_EN
        // ---------------- saturating counters ----------------
        check("cnt_dn1_cleared", 32'(a_cnt_dn1), 32'd0);
        a_dn1_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 9'h1FF;
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        a_in_valid = 1'b0;
        step();
        check("cnt_dn1_sat", 32'(a_cnt_dn1), 32'h0000FFFF);
        check("cnt_dn0_zero", 32'(a_cnt_dn0), 32'd0);
        check("cnt_up_zero",  32'(a_cnt_up),  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
